// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the traffic-light monitor.
//   - phase encoding (R, RA, G, A) as reported on the phase output
//   - {red,amber,green} lamp patterns for each legal phase
//   - error codes reported on err_code
//   - monitor FSM state type and the legal phase successor function
package traffic_pkg;

  localparam logic [1:0] PH_R  = 2'd0;
  localparam logic [1:0] PH_RA = 2'd1;
  localparam logic [1:0] PH_G  = 2'd2;
  localparam logic [1:0] PH_A  = 2'd3;

  // Lamp patterns in {red, amber, green} order.
  localparam logic [2:0] PAT_R  = 3'b100;
  localparam logic [2:0] PAT_RA = 3'b110;
  localparam logic [2:0] PAT_G  = 3'b001;
  localparam logic [2:0] PAT_A  = 3'b010;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_PAT   = 2'b01;
  localparam logic [1:0] ERR_TRANS = 2'b10;
  localparam logic [1:0] ERR_DWELL = 2'b11;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  // The legal sequence R -> RA -> G -> A -> R is a plain modulo-4 increment
  // of the phase encoding.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    return ph + 2'd1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts consecutive samples of the currently held phase.
// Ports:
//   clk, rst_n : shared with the parent (async active-low reset to 0)
//   load       : restart the count at 1 (new phase anchored or timeout)
//   inc        : count one more sample of the same phase
//   tc         : high while the count equals MAX_DWELL
// load has priority over inc.
module dwell_timer #(
  parameter int MAX_DWELL = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam int DW = $clog2(MAX_DWELL + 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= DW'(1);
    end else if (inc) begin
      cnt <= cnt + DW'(1);
    end
  end

  assign tc = (cnt == DW'(MAX_DWELL));

endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: receive-side checker for the traffic-light controller.
// Samples {red,amber,green} every clock, locks onto R -> RA -> G -> A -> R,
// flags illegal patterns, illegal transitions and over-long phases, and
// counts completed light cycles (A -> R advances). Status only; nothing here
// feeds back into the controller.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   clr               : sync clear of err, err_code and cycle_count
//   red, amber, green : lamp drives from the controller
//   locked            : tracking a legal sequence
//   phase             : last accepted phase (R=0, RA=1, G=2, A=3)
//   err_pulse         : one-cycle strobe per error event
//   err, err_code     : sticky flag and first error code since reset/clr
//   cycle_count       : completed cycles, wraps modulo 2^CNT_W
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int MAX_DWELL = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err_pulse,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  mon_state_e state, state_n;
  logic [2:0] pat;
  logic       pat_ok;
  logic [1:0] pat_ph;
  logic [1:0] phase_n;
  logic       err_ev;
  logic [1:0] err_ev_code;
  logic       cnt_inc;
  logic       dwell_load;
  logic       dwell_inc;
  logic       dwell_tc;

  assign pat = {red, amber, green};

  always_comb begin
    pat_ok = 1'b1;
    pat_ph = PH_R;
    case (pat)
      PAT_R:   pat_ph = PH_R;
      PAT_RA:  pat_ph = PH_RA;
      PAT_G:   pat_ph = PH_G;
      PAT_A:   pat_ph = PH_A;
      default: pat_ok = 1'b0;
    endcase
  end

  dwell_timer #(.MAX_DWELL(MAX_DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (dwell_load),
    .inc   (dwell_inc),
    .tc    (dwell_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SYNC;
      phase <= PH_R;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    err_ev      = 1'b0;
    err_ev_code = ERR_NONE;
    cnt_inc     = 1'b0;
    dwell_load  = 1'b0;
    dwell_inc   = 1'b0;
    case (state)
      ST_SYNC: begin
        // Illegal patterns are ignored here so the controller can self-start.
        if (pat_ok) begin
          state_n    = ST_TRACK;
          phase_n    = pat_ph;
          dwell_load = 1'b1;
        end
      end
      ST_TRACK: begin
        if (!pat_ok) begin
          err_ev      = 1'b1;
          err_ev_code = ERR_PAT;
          state_n     = ST_SYNC;
        end else if (pat_ph == phase) begin
          if (dwell_tc) begin
            // Timeout restarts the dwell window so a long hold re-reports.
            err_ev      = 1'b1;
            err_ev_code = ERR_DWELL;
            dwell_load  = 1'b1;
          end else begin
            dwell_inc = 1'b1;
          end
        end else if (pat_ph == next_phase(phase)) begin
          phase_n    = pat_ph;
          dwell_load = 1'b1;
          cnt_inc    = (phase == PH_A);
        end else begin
          // Skip or backward step: report, then re-anchor on what we saw.
          err_ev      = 1'b1;
          err_ev_code = ERR_TRANS;
          phase_n     = pat_ph;
          dwell_load  = 1'b1;
        end
      end
      default: state_n = ST_SYNC;
    endcase
  end

  assign locked = (state == ST_TRACK);

  // An error on the same edge as clr survives the clear; cycle_count does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse   <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      cycle_count <= '0;
    end else begin
      err_pulse <= err_ev;
      if (clr) begin
        err         <= err_ev;
        err_code    <= err_ev ? err_ev_code : ERR_NONE;
        cycle_count <= '0;
      end else begin
        if (err_ev) begin
          err <= 1'b1;
          if (!err) begin
            err_code <= err_ev_code;
          end
        end
        if (cnt_inc) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/traffic_monitor.md
Name: traffic_monitor

Overview:
- Synthesizable receive-side checker for the traffic-light controller outputs.
- Samples red/amber/green every clock and locks onto the legal sequence R(100) -> RA(110) -> G(001) -> A(010) -> R.
- Flags illegal patterns, illegal transitions and over-long phases; counts completed light cycles.
- Sits beside the traffic controller in the top level; it drives status only and never feeds back into the controller.

Parameters:
- MAX_DWELL, 15: maximum consecutive cycles one legal pattern may be held while locked; must be >= 1.
- CNT_W, 8: width of the completed-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of error and count state.
- red  in  1  red lamp from controller.
- amber  in  1  amber lamp from controller.
- green  in  1  green lamp from controller.
- locked  out  1  high while tracking a legal sequence.
- phase  out  2  last accepted phase: R=0, RA=1, G=2, A=3.
- err_pulse  out  1  one-cycle strobe on each error event.
- err  out  1  sticky error flag.
- err_code  out  2  code of the first error since reset or clr: 00 none, 01 illegal pattern, 10 illegal transition, 11 dwell timeout.
- cycle_count  out  CNT_W  completed A->R transitions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): locked=0, phase=0, err_pulse=0, err=0, err_code=00, cycle_count=0, dwell=0, FSM=SYNC.
- Timing: all outputs are registered and reflect the {red,amber,green} sample captured on the same rising edge, i.e. one edge of latency from input change.
- Pattern decode (RAG order): 100=R, 110=RA, 001=G, 010=A. The patterns 000, 011, 101 and 111 are illegal.
- FSM SYNC:
  - Illegal patterns are ignored, so the controller may self-start without raising an error.
  - First legal pattern: phase <= decoded value, locked <= 1, dwell <= 1, go to TRACK.
  - No cycle_count increment on entry.
- FSM TRACK, evaluated in this order each edge:
  - Illegal pattern: error 01, locked <= 0, go to SYNC, phase holds its last value.
  - Same pattern as phase: dwell increments. If dwell == MAX_DWELL before the increment, raise error 11 and set dwell <= 1 instead; remain in TRACK.
  - Next legal pattern in sequence: phase advances, dwell <= 1. An A->R advance increments cycle_count.
  - Any other legal pattern (skip or backward): error 10, re-anchor phase to the new pattern, dwell <= 1, remain in TRACK, no cycle_count change.
- Error event:
  - err_pulse is high for exactly that cycle.
  - err <= 1.
  - err_code is loaded only if err was 0, so the first error wins.
- clr (synchronous):
  - Clears err, err_code and cycle_count.
  - Does not affect locked, phase, dwell or FSM state.
  - If an error event occurs on the same edge, the error is recorded (err=1 with the new code) and cycle_count still clears.
- cycle_count wraps from 2^CNT_W-1 to 0 with no flag.
- Dwell counter width is $clog2(MAX_DWELL+1). With MAX_DWELL=1, every repeated sample is a timeout.
- Reset asserted mid-sequence returns to SYNC immediately. The first legal pattern after release locks again without error.

Decomposition:
- Package traffic_pkg holds:
  - phase encoding constants: PH_R=2'd0, PH_RA=2'd1, PH_G=2'd2, PH_A=2'd3;
  - RAG pattern constants: 3'b100, 3'b110, 3'b001, 3'b010;
  - error code constants: ERR_NONE, ERR_PAT, ERR_TRANS, ERR_DWELL;
  - a next-phase function.
- One sub-module, dwell_timer:
  - loadable counter with terminal-count output at MAX_DWELL;
  - inputs load and inc;
  - same clk/rst_n as the parent.

Test Plan:
- Reset, then drive 101,000,100,110,001,010,100 one per clock: no error; locked rises on the edge sampling 100; phase sequence 0,1,2,3,0; cycle_count=1.
- While locked in G (001), drive 011: err_pulse for one cycle, err=1, err_code=01, locked=0. Then drive 010: locked=1, phase=3, err_code stays 01.
- While locked in R (100), drive 001: err_code=10, phase=2, locked stays 1. Then drive 010, 100: cycle_count increments by 1.
- MAX_DWELL=3, hold 100 for 7 clocks after lock: err_pulse on the 4th and 7th samples, err_code=11.
- Run 256 clean R->RA->G->A cycles with CNT_W=8: cycle_count wraps to 0. Pulse clr during a clean run: err=0 and cycle_count=0 next edge, locked unchanged.
- Assert rst_n low between clock edges mid-RA: all outputs reset immediately without a clock edge. Release and drive 001: locked=1, phase=2, err=0.
